// File: rtl/stopwatch_display_scan.sv
// Four-digit multiplexed 7-segment scanner for the stopwatch BCD count.
// Per-frame shadow load, leading-zero blank, blink and ghosting guard.
module stopwatch_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 128,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_in,
    input  logic        RESET_N,
    input  logic [16:1] Q,
    input  logic        BLINK_EN,
    input  logic        LZ_BLANK,
    output logic [4:1]  AN,
    output logic [7:1]  SEG,
    output logic        DP,
    output logic        FRAME_TICK
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(BLINK_DIV + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [16:1]   shadow;
    logic [FW-1:0] frame_cnt;
    logic          phase;

    logic          wrap;
    logic          frame_end;
    logic [3:0]    digit;
    logic [7:1]    dec;
    logic          blank;
    logic [4:1]    an_hi;
    logic [7:1]    seg_hi;
    logic          dp_hi;

    assign wrap      = (cnt == CNT_LAST);
    assign frame_end = wrap && (idx == 2'd3);

    always_comb begin
        digit = 4'd0;
        unique case (idx)
            2'd0: digit = shadow[4:1];
            2'd1: digit = shadow[8:5];
            2'd2: digit = shadow[12:9];
            2'd3: digit = shadow[16:13];
        endcase
    end

    // active-high gfedcba; invalid BCD shows a dash
    always_comb begin
        dec = 7'b1000000;
        unique case (digit)
            4'd0: dec = 7'b0111111;
            4'd1: dec = 7'b0000110;
            4'd2: dec = 7'b1011011;
            4'd3: dec = 7'b1001111;
            4'd4: dec = 7'b1100110;
            4'd5: dec = 7'b1101101;
            4'd6: dec = 7'b1111101;
            4'd7: dec = 7'b0000111;
            4'd8: dec = 7'b1111111;
            4'd9: dec = 7'b1101111;
            default: dec = 7'b1000000;
        endcase
    end

    always_comb begin
        blank  = (cnt == '0)
               || (phase && BLINK_EN)
               || ((idx == 2'd3) && LZ_BLANK && (digit == 4'd0));
        an_hi  = 4'b0000;
        seg_hi = 7'b0000000;
        dp_hi  = 1'b0;
        if (!blank) begin
            an_hi  = 4'b0001 << idx;
            seg_hi = dec;
            dp_hi  = (idx == 2'd2);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!RESET_N) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= 16'h0000;
            frame_cnt  <= '0;
            phase      <= 1'b0;
            AN         <= {4{ACTIVE_LOW}};
            SEG        <= {7{ACTIVE_LOW}};
            DP         <= ACTIVE_LOW;
            FRAME_TICK <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + 1'b1;
            FRAME_TICK <= frame_end;
            if (wrap) begin
                idx <= idx + 2'd1;
            end
            if (frame_end) begin
                shadow <= Q;
            end
            // blink state is parked at a visible start while disabled
            if (!BLINK_EN) begin
                frame_cnt <= '0;
                phase     <= 1'b0;
            end else if (frame_end) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            AN  <= an_hi ^ {4{ACTIVE_LOW}};
            SEG <= seg_hi ^ {7{ACTIVE_LOW}};
            DP  <= dp_hi ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for stopwatch_display_scan (REFRESH_DIV=4, BLINK_DIV=2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_stopwatch_display_scan;

    logic        clk_in = 1'b0;
    logic        RESET_N;
    logic [16:1] Q;
    logic        BLINK_EN;
    logic        LZ_BLANK;
    logic [4:1]  AN;
    logic [7:1]  SEG;
    logic        DP;
    logic        FRAME_TICK;

    int checks = 0;
    int errors = 0;
    int k = 0;

    stopwatch_display_scan #(
        .REFRESH_DIV(4),
        .BLINK_DIV(2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in(clk_in),
        .RESET_N(RESET_N),
        .Q(Q),
        .BLINK_EN(BLINK_EN),
        .LZ_BLANK(LZ_BLANK),
        .AN(AN),
        .SEG(SEG),
        .DP(DP),
        .FRAME_TICK(FRAME_TICK)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // expected {AN,SEG,DP}, active-low, for output cycle k of a frame
    function automatic logic [11:0] exp_vec(int kk, logic [15:0] sh,
                                            bit lz, bit dark);
        int slot;
        logic [3:0] d;
        logic [6:0] s;
        logic [3:0] an;
        logic dp;
        slot = (kk / 4) % 4;
        d = sh[slot*4 +: 4];
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        if ((kk % 4 == 0) || dark || (slot == 3 && lz && d == 4'd0))
            return 12'hFFF;
        an = 4'b1111;
        an[slot] = 1'b0;
        dp = (slot == 2) ? 1'b0 : 1'b1;
        return {an, s, dp};
    endfunction

    task automatic run(int n, logic [15:0] sh, bit lz, bit dark);
        logic [11:0] e;
        logic t;
        for (int i = 0; i < n; i++) begin
            step();
            e = exp_vec(k, sh, lz, dark);
            t = (k % 16 == 15);
            checks++;
            assert ({AN, SEG, DP} === e) else begin
                errors++;
                $error("FAIL out k=%0d got %b expected %b",
                       k, {AN, SEG, DP}, e);
            end
            checks++;
            assert (FRAME_TICK === t) else begin
                errors++;
                $error("FAIL tick k=%0d got %b expected %b",
                       k, FRAME_TICK, t);
            end
            k++;
        end
    endtask

    task automatic check_reset(string tag);
        checks++;
        assert ({AN, SEG, DP} === 12'hFFF) else begin
            errors++;
            $error("FAIL %s out got %b expected %b",
                   tag, {AN, SEG, DP}, 12'hFFF);
        end
        checks++;
        assert (FRAME_TICK === 1'b0) else begin
            errors++;
            $error("FAIL %s tick got %b expected 0", tag, FRAME_TICK);
        end
    endtask

    initial begin
        RESET_N  = 1'b0;
        Q        = 16'h1234;
        BLINK_EN = 1'b0;
        LZ_BLANK = 1'b0;
        step();
        step();
        step();
        check_reset("reset");
        RESET_N = 1'b1;
        k = 0;

        run(16, 16'h0000, 0, 0);
        run(6, 16'h1234, 0, 0);
        Q = 16'h1235;
        run(10, 16'h1234, 0, 0);

        LZ_BLANK = 1'b1;
        run(8, 16'h1235, 1, 0);
        Q = 16'h0959;
        run(8, 16'h1235, 1, 0);
        run(16, 16'h0959, 1, 0);
        LZ_BLANK = 1'b0;
        run(8, 16'h0959, 0, 0);
        Q = 16'h1A20;
        run(8, 16'h0959, 0, 0);
        run(16, 16'h1A20, 0, 0);

        BLINK_EN = 1'b1;
        run(32, 16'h1A20, 0, 0);
        run(32, 16'h1A20, 0, 1);
        run(32, 16'h1A20, 0, 0);
        run(6, 16'h1A20, 0, 1);
        BLINK_EN = 1'b0;
        run(10, 16'h1A20, 0, 0);

        run(10, 16'h1A20, 0, 0);
        RESET_N = 1'b0;
        step();
        check_reset("midreset");
        RESET_N = 1'b1;
        k = 0;
        run(16, 16'h0000, 0, 0);
        run(16, 16'h1A20, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
